// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: column strobe, row sync, debounce, chord reject,
// and a single-entry valid/ready key output with overflow reporting.
module keypad_scan_debounce #(
    parameter int Rows     = 4,
    parameter int Columns  = 4,
    parameter int KEY_W    = 5,
    parameter int SETTLE   = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Rows-1:0]    rows,
    output logic [Columns-1:0] columns,
    output logic [KEY_W-1:0]   key,
    output logic               key_valid,
    input  logic               key_ready,
    output logic               multi_key,
    output logic               overflow
);

    localparam int CW    = $clog2(Columns);
    localparam int RW    = $clog2(Rows);
    localparam int CNT_W = $clog2(SETTLE + DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD
    } state_t;

    state_t            state;
    logic [Rows-1:0]   sync1;
    logic [Rows-1:0]   rs;
    logic [Rows-1:0]   pat;
    logic [CW-1:0]     col_idx;
    logic [CW-1:0]     next_col;
    logic [CNT_W-1:0]  cnt;
    logic [RW-1:0]     row_idx;
    logic [KEY_W-1:0]  code;
    logic [KEY_W-1:0]  acc_code;
    logic              acc;

    assign next_col = (col_idx == CW'(Columns - 1)) ? '0 : col_idx + 1'b1;

    // Only meaningful when pat holds exactly one zero.
    always_comb begin
        row_idx = '0;
        for (int i = 0; i < Rows; i++) begin
            if (!pat[i]) row_idx = RW'(i);
        end
    end

    assign code = KEY_W'(col_idx) * KEY_W'(Rows) + KEY_W'(row_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '1;
            rs        <= '1;
            state     <= ST_SCAN;
            col_idx   <= '0;
            cnt       <= '0;
            pat       <= '1;
            columns   <= {{(Columns - 1){1'b1}}, 1'b0};
            acc       <= 1'b0;
            acc_code  <= '0;
            multi_key <= 1'b0;
            overflow  <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            sync1     <= rows;
            rs        <= sync1;
            acc       <= 1'b0;
            multi_key <= 1'b0;
            overflow  <= 1'b0;

            unique case (state)
                ST_SCAN: begin
                    if (cnt == CNT_W'(SETTLE - 1)) begin
                        if (&rs) begin
                            cnt     <= '0;
                            col_idx <= next_col;
                            columns <= ~(Columns'(1) << next_col);
                        end else begin
                            pat   <= rs;
                            cnt   <= CNT_W'(1);
                            state <= ST_DEBOUNCE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs != pat) begin
                        state   <= ST_SCAN;
                        cnt     <= '0;
                        col_idx <= next_col;
                        columns <= ~(Columns'(1) << next_col);
                    end else if (cnt >= CNT_W'(DEBOUNCE - 1)) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        if ($onehot(~pat)) begin
                            acc      <= 1'b1;
                            acc_code <= code;
                        end else begin
                            multi_key <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Leave only after DEBOUNCE consecutive idle samples.
                    if (!(&rs)) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                        state   <= ST_SCAN;
                        cnt     <= '0;
                        col_idx <= next_col;
                        columns <= ~(Columns'(1) << next_col);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_SCAN;
                    cnt   <= '0;
                end
            endcase

            if (acc) begin
                if (!key_valid || key_ready) begin
                    key       <= acc_code;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule
